// File: rtl/br_resolve_ctrl.sv
// br_resolve_ctrl
//   Branch resolution for the EX stage. Selects the comparator mode, turns
//   the comparator flags into a taken/not-taken outcome, and compares the
//   resulting next PC with the one the front end fetched. On a mismatch it
//   issues a one-cycle registered flush with the corrected PC. Every resolved
//   legal branch is queued for predictor training, and saturating counters
//   track branches, mispredicts and dropped training updates.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_br_valid, i_stall       branch present in EX / EX not consumed
//   i_funct3, i_pc, i_imm     branch decode fields
//   i_pred_pc                 next PC fetched after this branch
//   o_br_un                   comparator mode (1 = unsigned)
//   i_br_less, i_br_equal     comparator flags
//   o_flush, o_redirect_pc    one-cycle flush and corrected next PC
//   o_illegal                 one-cycle pulse for funct3 010/011
//   o_upd_*, i_upd_ready      predictor training queue head and handshake
//   o_br_cnt, o_mispred_cnt,
//   o_drop_cnt                saturating performance counters
module br_resolve_ctrl #(
   parameter int UPD_DEPTH = 2,
   parameter int CNT_W     = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_br_valid,
   input  logic              i_stall,
   input  logic [2:0]        i_funct3,
   input  logic [31:0]       i_pc,
   input  logic [31:0]       i_imm,
   input  logic [31:0]       i_pred_pc,
   output logic              o_br_un,
   input  logic              i_br_less,
   input  logic              i_br_equal,
   output logic              o_flush,
   output logic [31:0]       o_redirect_pc,
   output logic              o_illegal,
   output logic              o_upd_valid,
   input  logic              i_upd_ready,
   output logic [31:0]       o_upd_pc,
   output logic              o_upd_taken,
   output logic              o_upd_mispred,
   output logic [CNT_W-1:0]  o_br_cnt,
   output logic [CNT_W-1:0]  o_mispred_cnt,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   localparam int AW   = $clog2(UPD_DEPTH);
   localparam int CNTW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic        mispred;
   } upd_t;

   upd_t            fifo_mem [UPD_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CNTW-1:0] count;

   logic        fire;
   logic        legal;
   logic        taken;
   logic        mispred;
   logic [31:0] actual_pc;
   logic        push;
   logic        pop;
   logic        full;
   logic        push_ok;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign o_br_un = i_funct3[1];

   // A branch sitting in EX while the flush is out is on the wrong path.
   assign fire = i_br_valid & ~i_stall & ~o_flush & i_rst_n;

   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      case (i_funct3)
         3'b000:  taken = i_br_equal;
         3'b001:  taken = ~i_br_equal;
         3'b100:  taken = i_br_less;
         3'b101:  taken = ~i_br_less;
         3'b110:  taken = i_br_less;
         3'b111:  taken = ~i_br_less;
         default: legal = 1'b0;
      endcase
   end

   assign actual_pc = taken ? (i_pc + i_imm) : (i_pc + 32'd4);
   assign mispred   = (actual_pc != i_pred_pc);

   assign push    = fire & legal;
   assign full    = (count == CNTW'(UPD_DEPTH));
   assign pop     = o_upd_valid & i_upd_ready;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign push_ok = push & (~full | pop);

   assign o_upd_valid   = (count != '0);
   assign o_upd_pc      = o_upd_valid ? fifo_mem[rd_ptr].pc      : 32'd0;
   assign o_upd_taken   = o_upd_valid ? fifo_mem[rd_ptr].taken   : 1'b0;
   assign o_upd_mispred = o_upd_valid ? fifo_mem[rd_ptr].mispred : 1'b0;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_flush       <= 1'b0;
         o_redirect_pc <= 32'd0;
         o_illegal     <= 1'b0;
         o_br_cnt      <= '0;
         o_mispred_cnt <= '0;
         o_drop_cnt    <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
      end else begin
         o_flush   <= push & mispred;
         o_illegal <= fire & ~legal;
         if (push & mispred)
            o_redirect_pc <= actual_pc;
         if (push)
            o_br_cnt <= sat_inc(o_br_cnt);
         if (push & mispred)
            o_mispred_cnt <= sat_inc(o_mispred_cnt);
         if (push & ~push_ok)
            o_drop_cnt <= sat_inc(o_drop_cnt);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         count <= count + CNTW'(push_ok) - CNTW'(pop);
      end
   end

   // Storage needs no reset: the head is masked to zero whenever empty.
   always_ff @(posedge i_clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= '{pc: i_pc, taken: taken, mispred: mispred};
   end

endmodule

// File: tb/tb_br_resolve_ctrl.sv
module tb_br_resolve_ctrl;

   localparam int DEPTH = 2;
   localparam int CW    = 4;
   localparam int CMAX  = 15;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_br_valid;
   logic          i_stall;
   logic [2:0]    i_funct3;
   logic [31:0]   i_pc;
   logic [31:0]   i_imm;
   logic [31:0]   i_pred_pc;
   logic          o_br_un;
   logic          i_br_less;
   logic          i_br_equal;
   logic          o_flush;
   logic [31:0]   o_redirect_pc;
   logic          o_illegal;
   logic          o_upd_valid;
   logic          i_upd_ready;
   logic [31:0]   o_upd_pc;
   logic          o_upd_taken;
   logic          o_upd_mispred;
   logic [CW-1:0] o_br_cnt;
   logic [CW-1:0] o_mispred_cnt;
   logic [CW-1:0] o_drop_cnt;

   br_resolve_ctrl #(.UPD_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_br_valid(i_br_valid), .i_stall(i_stall),
      .i_funct3(i_funct3), .i_pc(i_pc), .i_imm(i_imm), .i_pred_pc(i_pred_pc),
      .o_br_un(o_br_un), .i_br_less(i_br_less), .i_br_equal(i_br_equal),
      .o_flush(o_flush), .o_redirect_pc(o_redirect_pc), .o_illegal(o_illegal),
      .o_upd_valid(o_upd_valid), .i_upd_ready(i_upd_ready), .o_upd_pc(o_upd_pc),
      .o_upd_taken(o_upd_taken), .o_upd_mispred(o_upd_mispred),
      .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt), .o_drop_cnt(o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic        mis;
   } upd_t;

   upd_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        m_flush = 1'b0;
   logic [31:0] m_redirect = 32'd0;
   logic        m_illegal = 1'b0;
   int          m_br = 0;
   int          m_mis = 0;
   int          m_drop = 0;

   function automatic logic model_taken(input logic [2:0] f3, input logic lt, input logic eq);
      case (f3)
         3'b000:         return eq;
         3'b001:         return !eq;
         3'b100, 3'b110: return lt;
         3'b101, 3'b111: return !lt;
         default:        return 1'b0;
      endcase
   endfunction

   task automatic set_br(input logic v, input logic [2:0] f3, input logic lt, input logic eq,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] pred);
      i_br_valid = v; i_funct3 = f3; i_br_less = lt; i_br_equal = eq;
      i_pc = pc; i_imm = imm; i_pred_pc = pred;
   endtask

   // Scoreboard cycle: called at a negedge with inputs settled. Checks the
   // queue head on every pop, advances the model across the edge and checks
   // registered outputs on the following negedge.
   task automatic step();
      logic        fire, legal, tk, mp, pop;
      logic [31:0] apc;
      fire  = i_br_valid && !i_stall && !m_flush && i_rst_n;
      legal = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);
      tk    = model_taken(i_funct3, i_br_less, i_br_equal);
      apc   = tk ? i_pc + i_imm : i_pc + 32'd4;
      mp    = (apc != i_pred_pc);
      checks++;
      if (o_br_un !== i_funct3[1]) begin
         errors++; $display("FAIL br_un: got %b expected %b", o_br_un, i_funct3[1]);
      end
      checks++;
      if (o_upd_valid !== (sb_q.size() > 0)) begin
         errors++; $display("FAIL upd_valid: got %b expected %b", o_upd_valid, sb_q.size() > 0);
      end
      pop = i_upd_ready && (sb_q.size() > 0);
      if (pop) begin
         checks++;
         if ({o_upd_pc, o_upd_taken, o_upd_mispred} !== sb_q[0]) begin
            errors++;
            $display("FAIL upd_head: got pc=%h t=%b m=%b expected pc=%h t=%b m=%b",
                     o_upd_pc, o_upd_taken, o_upd_mispred, sb_q[0].pc, sb_q[0].taken, sb_q[0].mis);
         end
      end
      @(posedge i_clk);
      if (!i_rst_n) begin
         m_flush = 0; m_redirect = 0; m_illegal = 0; m_br = 0; m_mis = 0; m_drop = 0;
         sb_q.delete();
      end else begin
         m_flush   = fire && legal && mp;
         m_illegal = fire && !legal;
         if (m_flush) m_redirect = apc;
         if (pop) void'(sb_q.pop_front());
         if (fire && legal) begin
            if (m_br < CMAX) m_br++;
            if (mp && m_mis < CMAX) m_mis++;
            if (sb_q.size() < DEPTH) sb_q.push_back('{pc: i_pc, taken: tk, mis: mp});
            else if (m_drop < CMAX) m_drop++;
         end
      end
      @(negedge i_clk);
      checks++;
      if (o_flush !== m_flush) begin
         errors++; $display("FAIL flush: got %b expected %b", o_flush, m_flush);
      end
      if (m_flush) begin
         checks++;
         if (o_redirect_pc !== m_redirect) begin
            errors++; $display("FAIL redirect: got %h expected %h", o_redirect_pc, m_redirect);
         end
      end
      checks++;
      if (o_illegal !== m_illegal) begin
         errors++; $display("FAIL illegal: got %b expected %b", o_illegal, m_illegal);
      end
      checks++;
      if ({o_br_cnt, o_mispred_cnt, o_drop_cnt} !== {CW'(m_br), CW'(m_mis), CW'(m_drop)}) begin
         errors++;
         $display("FAIL counters: got br=%0d mis=%0d drop=%0d expected br=%0d mis=%0d drop=%0d",
                  o_br_cnt, o_mispred_cnt, o_drop_cnt, m_br, m_mis, m_drop);
      end
   endtask

   task automatic do_reset();
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      i_rst_n = 0;
      step();
      i_rst_n = 1;
   endtask

   task automatic test_reset();
      i_stall = 0; i_upd_ready = 0;
      do_reset();
      checks++;
      if ({o_flush, o_redirect_pc, o_illegal, o_upd_valid, o_upd_pc, o_upd_taken, o_upd_mispred,
           o_br_cnt, o_mispred_cnt, o_drop_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state: got flush=%b rpc=%h ill=%b uv=%b upc=%h br=%0d mis=%0d drop=%0d expected all zero",
                  o_flush, o_redirect_pc, o_illegal, o_upd_valid, o_upd_pc, o_br_cnt, o_mispred_cnt, o_drop_cnt);
      end
   endtask

   task automatic test_beq_mispredict();
      do_reset();
      i_upd_ready = 1;
      set_br(1, 3'b000, 0, 1, 32'h100, 32'h40, 32'h104);
      step();
      checks++;
      if (o_flush !== 1'b1 || o_redirect_pc !== 32'h140) begin
         errors++; $display("FAIL beq_flush: got flush=%b rpc=%h expected flush=1 rpc=00000140", o_flush, o_redirect_pc);
      end
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (o_flush !== 1'b0 || o_br_cnt !== 4'd1 || o_mispred_cnt !== 4'd1) begin
         errors++; $display("FAIL beq_after: got flush=%b br=%0d mis=%0d expected flush=0 br=1 mis=1", o_flush, o_br_cnt, o_mispred_cnt);
      end
      step();
   endtask

   task automatic test_bgeu_correct();
      do_reset();
      i_upd_ready = 0;
      set_br(1, 3'b111, 0, 0, 32'h200, 32'hFFFF_FFF8, 32'h1F8);
      #1;
      checks++;
      if (o_br_un !== 1'b1) begin
         errors++; $display("FAIL bgeu_br_un: got %b expected 1", o_br_un);
      end
      step();
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      checks++;
      if (o_flush !== 1'b0 || o_upd_valid !== 1'b1 || o_upd_pc !== 32'h200 ||
          o_upd_taken !== 1'b1 || o_upd_mispred !== 1'b0) begin
         errors++;
         $display("FAIL bgeu_entry: got flush=%b uv=%b pc=%h t=%b m=%b expected flush=0 uv=1 pc=00000200 t=1 m=0",
                  o_flush, o_upd_valid, o_upd_pc, o_upd_taken, o_upd_mispred);
      end
      step();
      i_upd_ready = 1;
      step();
   endtask

   task automatic test_shadow_squash();
      do_reset();
      i_upd_ready = 0;
      set_br(1, 3'b001, 0, 0, 32'h300, 32'h20, 32'h304);
      step();
      set_br(1, 3'b000, 0, 1, 32'h320, 32'h80, 32'h324);
      step();
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (o_flush !== 1'b0 || o_br_cnt !== 4'd1 || o_mispred_cnt !== 4'd1) begin
         errors++; $display("FAIL shadow_count: got flush=%b br=%0d mis=%0d expected flush=0 br=1 mis=1", o_flush, o_br_cnt, o_mispred_cnt);
      end
      i_upd_ready = 1;
      step();
      checks++;
      if (o_upd_valid !== 1'b0) begin
         errors++; $display("FAIL shadow_one_entry: got upd_valid=%b expected 0", o_upd_valid);
      end
   endtask

   task automatic test_fifo_full();
      do_reset();
      i_upd_ready = 0;
      for (int k = 1; k <= 3; k++) begin
         set_br(1, 3'b000, 0, 0, 32'(k * 16), 32'h40, 32'(k * 16 + 4));
         step();
      end
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      checks++;
      if (o_drop_cnt !== 4'd1 || o_upd_valid !== 1'b1 || o_upd_pc !== 32'h10) begin
         errors++; $display("FAIL fifo_drop: got drop=%0d uv=%b pc=%h expected drop=1 uv=1 pc=00000010", o_drop_cnt, o_upd_valid, o_upd_pc);
      end
      i_upd_ready = 1;
      step();
      step();
      checks++;
      if (o_upd_valid !== 1'b0) begin
         errors++; $display("FAIL fifo_drain: got upd_valid=%b expected 0", o_upd_valid);
      end
      i_upd_ready = 0;
      set_br(1, 3'b100, 1, 0, 32'h500, 32'h10, 32'h510);
      step();
      set_br(1, 3'b101, 1, 0, 32'h520, 32'h10, 32'h524);
      step();
      i_upd_ready = 1;
      set_br(1, 3'b110, 0, 0, 32'h540, 32'h10, 32'h544);
      step();
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      checks++;
      if (o_drop_cnt !== 4'd1 || o_upd_pc !== 32'h520) begin
         errors++; $display("FAIL fifo_push_pop_full: got drop=%0d head=%h expected drop=1 head=00000520", o_drop_cnt, o_upd_pc);
      end
      step();
      step();
      step();
   endtask

   task automatic test_illegal_stall();
      do_reset();
      i_upd_ready = 1;
      set_br(1, 3'b010, 0, 1, 32'h600, 32'h40, 32'h700);
      step();
      checks++;
      if (o_illegal !== 1'b1 || o_flush !== 1'b0 || o_br_cnt !== 4'd0 || o_upd_valid !== 1'b0) begin
         errors++; $display("FAIL illegal_pulse: got ill=%b flush=%b br=%0d uv=%b expected ill=1 flush=0 br=0 uv=0",
                            o_illegal, o_flush, o_br_cnt, o_upd_valid);
      end
      set_br(1, 3'b011, 0, 1, 32'h600, 32'h40, 32'h700);
      step();
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (o_illegal !== 1'b0) begin
         errors++; $display("FAIL illegal_one_cycle: got %b expected 0", o_illegal);
      end
      i_stall = 1;
      set_br(1, 3'b000, 0, 1, 32'h800, 32'h40, 32'h804);
      step();
      step();
      i_stall = 0;
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      checks++;
      if (o_flush !== 1'b0 || o_br_cnt !== 4'd0 || o_upd_valid !== 1'b0) begin
         errors++; $display("FAIL stall: got flush=%b br=%0d uv=%b expected flush=0 br=0 uv=0", o_flush, o_br_cnt, o_upd_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      i_upd_ready = 0;
      set_br(1, 3'b000, 0, 0, 32'h10, 32'h40, 32'h14);
      step();
      set_br(1, 3'b000, 0, 0, 32'h20, 32'h40, 32'h24);
      step();
      set_br(1, 3'b000, 0, 1, 32'h30, 32'h40, 32'h34);
      step();
      i_rst_n = 0;
      set_br(1, 3'b001, 0, 0, 32'h90, 32'h40, 32'h94);
      step();
      checks++;
      if ({o_flush, o_redirect_pc, o_illegal, o_upd_valid, o_upd_pc, o_br_cnt, o_mispred_cnt, o_drop_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got flush=%b rpc=%h uv=%b upc=%h br=%0d mis=%0d drop=%0d expected all zero",
                  o_flush, o_redirect_pc, o_upd_valid, o_upd_pc, o_br_cnt, o_mispred_cnt, o_drop_cnt);
      end
      i_rst_n = 1;
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      step();
   endtask

   task automatic test_back_to_back();
      do_reset();
      i_upd_ready = 1;
      for (int k = 0; k < 16; k++) begin
         set_br(1, 3'b101, k[0], 0, 32'h1000 + 32'(k * 8), 32'h100, 32'h0);
         i_pred_pc = k[0] ? i_pc + 32'd4 : i_pc + 32'h100;
         step();
      end
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (o_br_cnt !== 4'd15 || o_drop_cnt !== 4'd0) begin
         errors++; $display("FAIL br_cnt_saturate: got br=%0d drop=%0d expected br=15 drop=0", o_br_cnt, o_drop_cnt);
      end
      for (int k = 0; k < 17; k++) begin
         set_br(1, 3'b000, 0, 1, 32'h2000, 32'h40, 32'h2004);
         step();
         set_br(0, 3'b000, 0, 0, 0, 0, 0);
         step();
      end
      checks++;
      if (o_mispred_cnt !== 4'd15 || o_br_cnt !== 4'd15) begin
         errors++; $display("FAIL mis_cnt_saturate: got mis=%0d br=%0d expected mis=15 br=15", o_mispred_cnt, o_br_cnt);
      end
   endtask

   initial begin
      i_rst_n = 0; i_stall = 0; i_upd_ready = 0;
      set_br(0, 3'b000, 0, 0, 0, 0, 0);
      @(negedge i_clk);
      test_reset();
      test_beq_mispredict();
      test_bgeu_correct();
      test_shadow_squash();
      test_fifo_full();
      test_illegal_stall();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/br_resolve_ctrl.md
# br_resolve_ctrl

Branch resolution controller for the EX stage of the 5-stage RV32I pipeline. It configures the shared branch comparator (signed/unsigned select), decodes the comparator flags into a taken/not-taken outcome, and checks the outcome against the agree predictor's predicted next PC. On a mispredict it issues a registered flush/redirect. It also queues predictor training updates behind a valid/ready handshake and keeps saturating performance counters.

## Interface
- UPD_DEPTH, 2, depth of the predictor-update FIFO (power of two, ≥2)
- CNT_W, 32, width of performance counters
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_br_valid  in  1  EX holds a conditional branch (opcode 1100011)
- i_stall  in  1  pipeline stall; EX contents not consumed this cycle
- i_funct3  in  3  branch funct3
- i_pc  in  32  branch PC
- i_imm  in  32  sign-extended B-type immediate
- i_pred_pc  in  32  next PC the front end fetched after this branch
- o_br_un  out  1  comparator mode: 1 unsigned, 0 signed
- i_br_less  in  1  comparator rs1<rs2
- i_br_equal  in  1  comparator rs1==rs2
- o_flush  out  1  one-cycle flush of IF/ID/EX
- o_redirect_pc  out  32  correct next PC, valid while o_flush=1
- o_illegal  out  1  one-cycle pulse: funct3 010/011 fired
- o_upd_valid  out  1  update entry available
- i_upd_ready  in  1  predictor accepts update
- o_upd_pc  out  32  PC of resolved branch
- o_upd_taken  out  1  actual direction
- o_upd_mispred  out  1  entry was mispredicted
- o_br_cnt  out  CNT_W  resolved legal branches
- o_mispred_cnt  out  CNT_W  mispredicted branches
- o_drop_cnt  out  CNT_W  updates dropped on full FIFO

## Operation
- o_br_un = i_funct3[1], combinational, independent of i_br_valid.
- fire = i_br_valid & ~i_stall & ~o_flush & i_rst_n. A branch in EX while o_flush=1 is wrong-path and ignored.
- Taken decode:
  - 000 BEQ = equal
  - 001 BNE = ~equal
  - 100 BLT = less
  - 101 BGE = ~less
  - 110 BLTU = less
  - 111 BGEU = ~less
- Illegal funct3 (010/011): the branch is treated as not taken and pulses o_illegal. It does not count, does not flush and does not push an update.
- actual_pc = taken ? (i_pc + i_imm) : (i_pc + 4), both mod 2^32, wrap ignored.
- mispred = (actual_pc != i_pred_pc). This covers both a wrong direction and a wrong target.
- On a legal fire:
  - o_br_cnt increments.
  - If mispred: o_mispred_cnt increments, and o_flush=1 / o_redirect_pc=actual_pc are registered for exactly one cycle.
  - {i_pc, taken, mispred} is pushed to the FIFO.
- FIFO behaviour:
  - FIFO order; head is presented on o_upd_*.
  - A pop occurs when o_upd_valid & i_upd_ready.
  - Push while full with no pop in the same cycle: the new entry is dropped and o_drop_cnt increments.
  - Push while full with a pop in the same cycle: the push is accepted.
  - o_upd_* are stable while o_upd_valid=1 and i_upd_ready=0.
- All counters saturate at 2^CNT_W−1 and never wrap.
- Reset values: o_flush=0, o_redirect_pc=0, o_illegal=0, o_upd_valid=0, o_upd_pc=0, o_upd_taken=0, o_upd_mispred=0, all counters=0, FIFO empty.

## Timing
- o_br_un: zero latency (same cycle as i_funct3).
- o_flush, o_redirect_pc, o_illegal: registered, asserted the cycle after fire, held for one cycle.
- Back-to-back flushes are impossible, because fire is masked while o_flush=1.
- Update entry is visible on o_upd_* the cycle after push at the earliest.
- Throughput: one push and one pop per cycle.
- Counters reflect a fire one cycle after it.
- Reset asserted mid-operation: all state clears at that edge. A fire in the reset cycle has no effect, and any pending flush or FIFO entries are lost.

## Test plan
- **BEQ mispredict:** fire BEQ with equal=1, pc=0x100, imm=0x40, pred_pc=0x104. Next cycle: o_flush=1 and o_redirect_pc=0x140. The cycle after: o_flush=0. o_mispred_cnt=1, o_br_cnt=1.
- **BGEU correct, o_br_un check:** funct3=111, less=0, pc=0x200, imm=−8, pred_pc=0x1F8. o_br_un=1 in the same cycle, no flush. Update entry reads {0x200, taken=1, mispred=0}.
- **Shadow squash:** mispredicted branch at cycle N, then i_br_valid=1 at N+1 while o_flush=1. Second branch not counted, no second flush, only one FIFO entry.
- **FIFO full/drop:** UPD_DEPTH=2, i_upd_ready=0, three legal fires. Two entries held, o_drop_cnt=1. Raise ready: entries pop in order over 2 cycles, then o_upd_valid=0. Also: full FIFO with push and pop in the same cycle: no drop.
- **Illegal and stall:** funct3=010 fire gives o_illegal pulse, no count, no flush, no push. i_stall=1 with i_br_valid=1: no state change.
- **Reset mid-operation:** i_rst_n=0 in the cycle after a mispredict fire, with 2 entries queued. All outputs 0 next cycle and FIFO empty. Counter saturation checked with CNT_W=4: 16 fires leave o_br_cnt=15.
